// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared definitions for the windowed pattern detector: state encodings and default widths.
package pattern_detect_ctrl_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/pattern_match_shift.sv
// Serial history shift register with fill counter and a combinational pattern comparator.
module pattern_match_shift
    import pattern_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  cand_s;

    assign cand_s = {hist_r, in_bit};

    // History and fill count; fill stops once a full pattern's worth of history exists.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_r <= '0;
            fill_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
            fill_r <= '0;
        end else if (shift_en) begin
            hist_r <= cand_s[PAT_W-2:0];
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // Mealy compare of the in-flight bit appended to the stored history.
    always_comb begin
        match = 1'b0;
        if (shift_en && (fill_r == FILL_MAX) && (cand_s == pattern)) begin
            match = 1'b1;
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Windowed controller: arms on start, examines cfg_window valid bits, counts overlapping matches.
module pattern_detect_ctrl
    import pattern_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [WIN_W-1:0] first_hit_pos,
    output logic             any_hit
);

    state_t           state_r;
    state_t           next_s;
    logic [PAT_W-1:0] pat_r;
    logic [WIN_W-1:0] win_r;
    logic [WIN_W-1:0] bit_idx_r;
    logic             accept_s;
    logic             take_s;
    logic             last_s;
    logic             match_s;
    logic             busy_s;
    logic             done_s;

    assign accept_s = (state_r == ST_IDLE) && start;
    assign take_s   = (state_r == ST_RUN) && in_valid;
    assign last_s   = take_s && (bit_idx_r == (win_r - WIN_W'(1)));

    pattern_match_shift #(
        .PAT_W (PAT_W)
    ) u_match (
        .clock    (clock),
        .reset    (reset),
        .clr      (accept_s),
        .shift_en (take_s),
        .in_bit   (in_bit),
        .pattern  (pat_r),
        .match    (match_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a zero-length window skips RUN entirely.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = (cfg_window == WIN_W'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_RUN;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Output decode: busy/done are looked ahead so their registers align with the state.
    always_comb begin
        busy_s = (next_s == ST_RUN);
        done_s = (next_s == ST_DONE);
        hit    = match_s;
    end

    // Registered status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= done_s;
        end
    end

    // Captured configuration, bit index and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pat_r         <= '0;
            win_r         <= '0;
            bit_idx_r     <= '0;
            hit_count     <= '0;
            first_hit_pos <= '0;
            any_hit       <= 1'b0;
        end else if (accept_s) begin
            pat_r         <= cfg_pattern;
            win_r         <= cfg_window;
            bit_idx_r     <= '0;
            hit_count     <= '0;
            first_hit_pos <= '0;
            any_hit       <= 1'b0;
        end else if (take_s) begin
            bit_idx_r <= bit_idx_r + WIN_W'(1);
            if (match_s) begin
                if (hit_count != {CNT_W{1'b1}}) begin
                    hit_count <= hit_count + CNT_W'(1);
                end else begin
                    hit_count <= hit_count;
                end
                if (!any_hit) begin
                    first_hit_pos <= bit_idx_r;
                    any_hit       <= 1'b1;
                end else begin
                    first_hit_pos <= first_hit_pos;
                    any_hit       <= any_hit;
                end
            end else begin
                hit_count     <= hit_count;
                first_hit_pos <= first_hit_pos;
                any_hit       <= any_hit;
            end
        end else begin
            bit_idx_r     <= bit_idx_r;
            hit_count     <= hit_count;
            first_hit_pos <= first_hit_pos;
            any_hit       <= any_hit;
        end
    end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
Windowed controller around a 4-bit serial sequence detector with a programmable pattern. It is armed by a start pulse, examines exactly cfg_window valid serial bits, and counts overlapping pattern matches with a Mealy hit pulse. It reports hit count, first-hit position and completion to a host sequencer. It sits between the serial bit source and the lab status/readout logic.

Parameters:
PAT_W, 4, pattern length in bits (fixed at 4 for this revision)
CNT_W, 8, width of hit_count (saturating)
WIN_W, 8, width of cfg_window, bit index and first_hit_pos

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
start  input  1  arm request pulse; honoured only in IDLE
cfg_pattern  input  PAT_W  target pattern; bit [PAT_W-1] is first in time; captured on accepted start
cfg_window  input  WIN_W  number of valid bits to examine; captured on accepted start
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
busy  output  1  high in RUN
hit  output  1  Mealy match pulse, combinational: same cycle as the completing bit
done  output  1  one-cycle pulse when window completes
hit_count  output  CNT_W  matches in last/current window, saturating
first_hit_pos  output  WIN_W  0-based bit index of first completing bit; valid when any_hit=1
any_hit  output  1  at least one match in the window

Behaviour:
- Reset (sync, active-high, reset=1 at posedge): state=IDLE; busy=0, done=0, hit_count=0, first_hit_pos=0, any_hit=0, shift history and fill count cleared, bit index=0. Reset has priority over everything, including mid-RUN; the window is abandoned with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: start=1 -> capture cfg_pattern/cfg_window, clear hit_count, first_hit_pos, any_hit, history, fill count and bit index. If captured window=0 go to DONE, else go to RUN. Results from the previous window hold until an accepted start.
- RUN: busy=1. In-cycle with in_valid=1 and in_bit=b, candidate = {hist[2:0], b}. hit = in_valid & (fill>=3) & (candidate==pattern), with fill counting bits already taken this window. At posedge: hist<=candidate, fill saturates at 3, bit index+1. in_valid=0 -> nothing changes and hit=0. Overlapping matches count; for example, 0101 matches twice in 0101 01.
- On hit: hit_count+1, saturating at 2^CNT_W-1. If any_hit=0, first_hit_pos<=current bit index and any_hit<=1.
- Window end: valid bit with bit index == window-1 -> next state DONE. That last bit is still evaluated for a hit.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. The done cycle is the cycle after the last accepted bit.
- start in RUN or DONE is ignored (not queued). in_valid outside RUN is ignored and hit=0.
- hit is combinational from state, hist, fill, pattern, in_valid and in_bit. All other outputs are registered.

Decomposition:
- Shared package: state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default widths PAT_W/CNT_W/WIN_W.
- Sub-module pattern_match_shift: history shift register, fill counter, and combinational comparator producing match. Inputs: clock, reset, clr, shift_en, in_bit, pattern. The controller owns the FSM, counters and result registers.

Test Plan:
- pattern=4'b0101, window=8, bits 0,1,0,1,0,1,1,0 on consecutive cycles -> hit at bit indices 3 and 5; hit_count=2, first_hit_pos=3, any_hit=1; done one cycle after bit 7; busy low in the done cycle.
- Same stream with in_valid low for 2 cycles between every bit -> identical results; hit never asserted in idle cycles; done one cycle after the last valid bit.
- pattern=4'b1111, window=6, bits all 1 -> hits at indices 3, 4, 5; hit_count=3, first_hit_pos=3. Then window=3, all 1 -> hit_count=0, any_hit=0.
- window=0 -> start, then done pulse on the next cycle with busy never high; hit_count=0. Also: start pulsed during RUN is ignored and the window length is unchanged.
- CNT_W=2 override, pattern=4'b0000, window=10, all zeros -> 7 matches, hit_count saturates at 3.
- Reset asserted for one cycle after 4 bits of a window=8 run -> next cycle: IDLE, busy=0, hit_count=0, no done pulse. A subsequent start runs a clean window with no history carried over (first 3 bits cannot hit).
